rr_tree_arbiter: RTL and testbench
==================================

Name: rr_tree_arbiter

Overview:
- Sequential round-robin arbiter that shares one resource among 16 requesters.
- Wraps a rotating-priority pick, built from 4-input priority cells in a 4x4 tree, with a state machine.
- Grants are registered and held until the owner releases, so the resource has one owner per tenure.
- Sits between requester blocks and the shared bus/resource; drives the resource's select from Grant_Id_OUT.

Parameters:
- NUM_REQ, 16, number of requesters; only 16 is supported (4x4 tree).
- ID_W, 4, width of the grant index (log2 NUM_REQ).
- MAX_TENURE, 64, maximum grant duration in cycles; used only with ARB_TIMEOUT_EN; legal range 2..65535.

Ports:
- CLK  input  1  clock, rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- Request_IN  input  NUM_REQ  per-requester request level; must be held while waiting and while owning.
- Release_IN  input  1  owner finished; sampled only in OWNED.
- Grant_OUT  output  NUM_REQ  registered one-hot grant; all-zero when no owner.
- Grant_Valid_OUT  output  1  high while a grant is held (equals |Grant_OUT).
- Grant_Id_OUT  output  ID_W  binary index of current owner; holds last owner when Grant_Valid_OUT=0.
- Request_OUT  output  1  combinational |Request_IN, for cascading into an upstream tree.
- Preempt_OUT  output  1  one-cycle pulse when a tenure is force-ended by timeout.

Behaviour:
- Reset (async assert, sync deassert to CLK): state=IDLE, Grant_OUT=0, Grant_Valid_OUT=0, Grant_Id_OUT=0, pointer=0, tenure counter=0, Preempt_OUT=0.
- State IDLE:
  - If |Request_IN, pick the first set bit at index >= pointer, wrapping from 15 to 0.
  - On the next edge: Grant_OUT=onehot(pick), Grant_Id_OUT=pick, state=OWNED.
  - Latency from request sampled to grant visible: 1 cycle.
  - Release_IN is ignored in IDLE.
- State OWNED, release condition: Release_IN=1, or Request_IN[Grant_Id_OUT]=0 (owner dropped its request).
  - On the release edge: Grant_OUT=0, pointer=(Grant_Id_OUT+1) mod 16, state=GAP.
- State GAP: exactly one dead cycle with no grant for bus turnaround, then state=IDLE unconditionally.
  - Minimum spacing between two tenures is therefore 2 idle cycles: the GAP cycle and the IDLE decide cycle.
- Fairness: the pointer advances only at the end of a tenure. A requester held continuously is granted within 15 tenures.
- Simultaneous Release_IN and a new request from the owner: the release wins; the owner competes again with the pointer already advanced past it.
- Requests arriving or dropping in OWNED have no effect except the owner-drop rule.
- Grant_Id_OUT is stable for the entire tenure. Grant_OUT never has more than one bit set.
- Reset mid-tenure: grant is removed immediately (asynchronous); no Preempt_OUT pulse.
- Request_OUT is purely combinational and independent of state.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A tenure counter clears on grant and increments each OWNED cycle.
  - If the counter reaches MAX_TENURE-1 with no release condition, the tenure ends on the next edge with the same effects as a release.
  - Preempt_OUT=1 for that one cycle, aligned with Grant_OUT going to 0.
  - A normal release on the same cycle wins: no preempt pulse.
- Undefined: no counter is instantiated, Preempt_OUT is tied to 0, and tenures are unbounded.

Decomposition:
- Shared package arb_pkg:
  - constants ARB_NUM_REQ=16 and ARB_ID_W=4;
  - state enum arb_state_t {ARB_IDLE, ARB_OWNED, ARB_GAP};
  - onehot-to-index function.
- One natural sub-module, rr_pick16:
  - combinational rotating-priority pick;
  - implementation: mask requests below the pointer, run a masked and an unmasked 4x4 priority tree, select the masked result if non-zero.
  - Outputs: pick index and a valid flag.

Test Plan:
- Reset, then Request_IN=16'h0000 for 10 cycles -> Grant_OUT stays 0, Grant_Valid_OUT=0, Request_OUT=0.
- Request_IN=16'h0011 from reset -> Grant_OUT=16'h0001 one cycle later. Release, then GAP -> Grant_OUT=16'h0010 (pointer=1).
- Request_IN=16'hFFFF held, Release_IN pulsed at the 3rd cycle of each tenure -> Grant_Id_OUT sequence 0,1,2,…,15,0, each tenure separated by exactly 2 no-grant cycles.
- Owner id 5 drops Request_IN[5] with Release_IN=0, others requesting 16'h8004 -> grant clears next edge, then the next grant goes to id 15 (first set bit at or after pointer 6).
- ARB_TIMEOUT_EN, MAX_TENURE=4, Request_IN=16'h0008 held, no release -> Grant_OUT=16'h0008 for exactly 4 cycles, then Preempt_OUT pulses 1 cycle, and id 3 is re-granted after the GAP.
- RESET_N asserted mid-tenure (owner 7) -> Grant_OUT=0 within the same cycle with no clock edge; after deassert with 16'h0080 still requesting, the grant returns to 7 one cycle later (pointer=0).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin tree arbiter: sizes, FSM states
// and a one-hot to binary index helper.
package arb_pkg;

  localparam int ARB_NUM_REQ = 16;
  localparam int ARB_ID_W    = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWNED,
    ARB_GAP
  } arb_state_t;

  // OR-combine the indices of set bits; exact for a one-hot (or zero) input.
  function automatic logic [ARB_ID_W-1:0] onehot_to_idx(input logic [ARB_NUM_REQ-1:0] oh);
    logic [ARB_ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_NUM_REQ; i++) begin
      if (oh[i]) idx = idx | ARB_ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational rotating-priority pick over 16 requesters.
// Requests below the pointer are masked off; a masked and an unmasked 4x4
// priority tree run in parallel and the masked result wins when non-empty,
// which gives "first set bit at or after ptr, wrapping 15 -> 0".
module rr_pick16
  import arb_pkg::*;
(
  input  logic [ARB_NUM_REQ-1:0] req,
  input  logic [ARB_ID_W-1:0]    ptr,
  output logic [ARB_ID_W-1:0]    pick,
  output logic                   valid
);

  // Lowest-index-first priority encoder for one 4-input cell.
  function automatic logic [1:0] pri4(input logic [3:0] v);
    logic [1:0] r;
    casez (v)
      4'b???1: r = 2'd0;
      4'b??10: r = 2'd1;
      4'b?100: r = 2'd2;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  logic [ARB_NUM_REQ-1:0] mask;
  logic [ARB_NUM_REQ-1:0] req_m;
  logic [3:0]             grp_v_m;
  logic [3:0]             grp_v_u;
  logic [1:0]             grp_i_m [4];
  logic [1:0]             grp_i_u [4];
  logic [1:0]             top_m;
  logic [1:0]             top_u;

  // Keep only requesters at index >= ptr.
  always_comb begin
    mask = ~((16'd1 << ptr) - 16'd1);
  end

  assign req_m = req & mask;

  // Leaf level: four 4-input cells for each of the two trees.
  for (genvar gi = 0; gi < 4; gi++) begin : g_leaf
    assign grp_v_m[gi] = |req_m[4*gi +: 4];
    assign grp_v_u[gi] = |req[4*gi +: 4];
    assign grp_i_m[gi] = pri4(req_m[4*gi +: 4]);
    assign grp_i_u[gi] = pri4(req[4*gi +: 4]);
  end

  // Root level picks the winning group, leaf index supplies the low bits.
  assign top_m = pri4(grp_v_m);
  assign top_u = pri4(grp_v_u);
  assign valid = |grp_v_u;
  assign pick  = (|grp_v_m) ? {top_m, grp_i_m[top_m]} : {top_u, grp_i_u[top_u]};

endmodule

// File: rtl/rr_tree_arbiter.sv
// Sequential round-robin arbiter for 16 requesters with held grants.
// IDLE picks an owner, OWNED holds the grant until release or owner drop,
// GAP inserts one dead turnaround cycle. The pointer moves past the owner
// only when a tenure ends.
// Optional macro ARB_TIMEOUT_EN bounds each tenure to MAX_TENURE cycles and
// pulses Preempt_OUT when a tenure is force-ended.
module rr_tree_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ    = ARB_NUM_REQ,
  parameter int ID_W       = ARB_ID_W,
  parameter int MAX_TENURE = 64
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [NUM_REQ-1:0] Request_IN,
  input  logic               Release_IN,
  output logic [NUM_REQ-1:0] Grant_OUT,
  output logic               Grant_Valid_OUT,
  output logic [ID_W-1:0]    Grant_Id_OUT,
  output logic               Request_OUT,
  output logic               Preempt_OUT
);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               preempt_q, preempt_d;

  logic [ID_W-1:0]    pick;
  logic               pick_valid;
  logic               rel;
  logic               timeout;

  rr_pick16 u_pick (
    .req   (Request_IN),
    .ptr   (ptr_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  // Tenure ends when the owner says so or stops requesting.
  assign rel = Release_IN | ~Request_IN[id_q];

`ifdef ARB_TIMEOUT_EN
  logic [15:0] tenure_q, tenure_d;

  assign timeout = (tenure_q == 16'(MAX_TENURE - 1));

  // Tenure counter: parked at zero outside OWNED, counts each owned cycle.
  always_comb begin
    tenure_d = '0;
    if (state_q == ARB_OWNED) tenure_d = tenure_q + 16'd1;
  end

  // Tenure counter register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) tenure_q <= '0;
    else          tenure_q <= tenure_d;
  end
`else
  logic unused_max_tenure;
  assign unused_max_tenure = (MAX_TENURE > 1);
  assign timeout           = 1'b0;
`endif

  // Next-state and next-grant logic of the IDLE / OWNED / GAP machine.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    preempt_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d = NUM_REQ'(1) << pick;
          id_d    = onehot_to_idx(grant_d);
          state_d = ARB_OWNED;
        end
      end
      ARB_OWNED: begin
        if (rel || timeout) begin
          grant_d   = '0;
          ptr_d     = id_q + 1'b1;
          preempt_d = ~rel;
          state_d   = ARB_GAP;
        end
      end
      ARB_GAP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, grant, owner id, pointer and preempt registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      id_q      <= '0;
      ptr_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      preempt_q <= preempt_d;
    end
  end

  assign Grant_OUT       = grant_q;
  assign Grant_Valid_OUT = |grant_q;
  assign Grant_Id_OUT    = id_q;
  assign Request_OUT     = |Request_IN;
  assign Preempt_OUT     = preempt_q;

endmodule

// File: tb/tb_rr_tree_arbiter.sv
// Scoreboard bench for rr_tree_arbiter: expected owner ids are queued when
// stimulus is applied and compared each time a new grant appears.
module tb_rr_tree_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int MT = 4;
`else
  localparam int MT = 64;
`endif

  logic        CLK;
  logic        RESET_N;
  logic [15:0] Request_IN;
  logic        Release_IN;
  logic [15:0] Grant_OUT;
  logic        Grant_Valid_OUT;
  logic [3:0]  Grant_Id_OUT;
  logic        Request_OUT;
  logic        Preempt_OUT;

  rr_tree_arbiter #(.NUM_REQ(16), .ID_W(4), .MAX_TENURE(MT)) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .Request_IN      (Request_IN),
    .Release_IN      (Release_IN),
    .Grant_OUT       (Grant_OUT),
    .Grant_Valid_OUT (Grant_Valid_OUT),
    .Grant_Id_OUT    (Grant_Id_OUT),
    .Request_OUT     (Request_OUT),
    .Preempt_OUT     (Preempt_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   n_checks = 0;
  int   n_errors = 0;
  int   sb_q[$];
  logic prev_valid = 1'b0;
  int   idle_cnt = 0;
  logic gap_chk = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample on the falling edge; new grants pop the scoreboard.
  task automatic cycle();
    int e;
    @(posedge CLK);
    @(negedge CLK);
    if (Grant_Valid_OUT && !prev_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_grant", 32'(Grant_Id_OUT), 32'hFFFF);
      end else begin
        e = sb_q.pop_front();
        $display("grant id=%0d expected=%0d onehot=0x%04h idle_before=%0d",
                 Grant_Id_OUT, e, Grant_OUT, idle_cnt);
        check("grant_id", 32'(Grant_Id_OUT), 32'(e));
        check("grant_onehot", 32'(Grant_OUT), 32'(1) << e);
        if (gap_chk) check("gap_cycles", 32'(idle_cnt), 32'd2);
      end
    end
    if (Grant_Valid_OUT) idle_cnt = 0;
    else                 idle_cnt++;
    prev_valid = Grant_Valid_OUT;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!Grant_Valid_OUT && n < budget) begin
      cycle();
      n++;
    end
    if (!Grant_Valid_OUT) check("wait_grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    RESET_N    = 1'b0;
    Request_IN = '0;
    Release_IN = 1'b0;
    cycle();
    cycle();
    RESET_N = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RESET_N    = 1'b0;
    Request_IN = '0;
    Release_IN = 1'b0;
    // Reset state and idle behaviour with no requests.
    do_reset();
    check("rst_grant", 32'(Grant_OUT), 32'd0);
    check("rst_valid", 32'(Grant_Valid_OUT), 32'd0);
    check("rst_id", 32'(Grant_Id_OUT), 32'd0);
    check("rst_preempt", 32'(Preempt_OUT), 32'd0);
    for (int i = 0; i < 10; i++) begin
      Release_IN = (i % 3 == 0);
      cycle();
      check("idle_valid", 32'(Grant_Valid_OUT), 32'd0);
      check("idle_req_out", 32'(Request_OUT), 32'd0);
    end
    Release_IN = 1'b0;

    // Two requesters: 0 first, then 4 once the pointer has moved to 1.
    do_reset();
    Request_IN = 16'h0011;
    sb_q.push_back(0);
    #1 check("req_out_comb", 32'(Request_OUT), 32'd1);
    cycle();
    check("lat1_valid", 32'(Grant_Valid_OUT), 32'd1);
    Release_IN = 1'b1;
    cycle();
    Release_IN = 1'b0;
    check("gap_no_grant", 32'(Grant_OUT), 32'd0);
    sb_q.push_back(4);
    cycle();
    check("idle_no_grant", 32'(Grant_OUT), 32'd0);
    cycle();
    check("second_grant", 32'(Grant_OUT), 32'h0010);
    Release_IN = 1'b1;
    Request_IN = '0;
    cycle();
    Release_IN = 1'b0;
    cycle();
    cycle();

    // All requesting: full rotation 0..15 then 0, release on 3rd tenure cycle.
    do_reset();
    Request_IN = 16'hFFFF;
    for (int i = 0; i < 16; i++) sb_q.push_back(i);
    sb_q.push_back(0);
    for (int t = 0; t < 17; t++) begin
      wait_valid(8);
      gap_chk = 1'b1;
      cycle();
      check("tenure_held", 32'(Grant_Valid_OUT), 32'd1);
      Release_IN = 1'b1;
      cycle();
      Release_IN = 1'b0;
      if (t == 16) Request_IN = '0;
    end
    gap_chk = 1'b0;
    cycle();
    cycle();
    check("rot_preempt", 32'(Preempt_OUT), 32'd0);

    // Owner 5 drops its request; next owner is 15 (first at/after 6).
    // Release is held during the IDLE decide cycle to show it is ignored there.
    do_reset();
    Request_IN = 16'h0020;
    Release_IN = 1'b1;
    sb_q.push_back(5);
    sb_q.push_back(15);
    cycle();
    Release_IN = 1'b0;
    check("own5_valid", 32'(Grant_Valid_OUT), 32'd1);
    cycle();
    check("own5_held", 32'(Grant_Id_OUT), 32'd5);
    Request_IN = 16'h8004;
    cycle();
    check("drop_clears", 32'(Grant_Valid_OUT), 32'd0);
    check("drop_no_preempt", 32'(Preempt_OUT), 32'd0);
    check("drop_id_holds", 32'(Grant_Id_OUT), 32'd5);
    cycle();
    cycle();
    check("after_drop_id", 32'(Grant_Id_OUT), 32'd15);
    Request_IN = '0;
    cycle();
    cycle();
    cycle();

`ifdef ARB_TIMEOUT_EN
    // Bounded tenure: owner 3 never releases.
    do_reset();
    Request_IN = 16'h0008;
    sb_q.push_back(3);
    sb_q.push_back(3);
    wait_valid(4);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("to_held", 32'(Grant_OUT), 32'h0008);
      check("to_no_preempt", 32'(Preempt_OUT), 32'd0);
    end
    cycle();
    check("to_cleared", 32'(Grant_OUT), 32'd0);
    check("to_preempt", 32'(Preempt_OUT), 32'd1);
    cycle();
    check("to_preempt_end", 32'(Preempt_OUT), 32'd0);
    cycle();
    check("to_regrant", 32'(Grant_OUT), 32'h0008);
    Request_IN = '0;
    cycle();
    cycle();
    cycle();
`endif

    // Asynchronous reset in the middle of owner 7's tenure.
    do_reset();
    Request_IN = 16'h0080;
    sb_q.push_back(7);
    sb_q.push_back(7);
    cycle();
    check("own7_valid", 32'(Grant_Valid_OUT), 32'd1);
    #2 RESET_N = 1'b0;
    #1 check("async_grant", 32'(Grant_OUT), 32'd0);
    check("async_preempt", 32'(Preempt_OUT), 32'd0);
    cycle();
    cycle();
    RESET_N = 1'b1;
    cycle();
    check("post_rst_grant", 32'(Grant_OUT), 32'h0080);
    Request_IN = '0;
    cycle();
    cycle();

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
